pipe_stage_buf: RTL and testbench

//   Parametrised elastic pipeline-stage register. It replaces the fixed
//   one-deep stall/flush stage registers between the pipeline stages.
//   - Holds up to DEPTH payload words in FIFO order.
//   - Valid/ready handshake on both sides, plus the pipeline's stall_i/flush_i controls.
//   - in_ready_o depends only on registered state, so upstream never sees a

---
 rtl/pipe_stage_buf.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
`timescale 1ns/1ps
// pipe_stage_buf: elastic pipeline-stage register holding up to DEPTH words in
// FIFO order. It uses valid/ready handshakes on both sides and adds the
// pipeline's stall/flush controls.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-low reset
//   flush_i      synchronous kill of all held and incoming words
//   stall_i      downstream freeze: blocks pop only
//   in_valid_i   upstream word present
//   in_ready_o   buffer can accept a word (from registered state only)
//   in_data_i    upstream payload
//   out_valid_o  head word present (masked by flush_i)
//   out_ready_i  downstream accepts the head word
//   out_data_o   head payload (stale mem[rd_ptr] when empty)
//   count_o      current occupancy, 0..DEPTH
//
// Build option
//   PIPE_STAGE_BUF_BYPASS_EN: an empty buffer forwards the incoming word in the
//   same cycle. This adds a combinational in_* -> out_* path. When the macro is
//   undefined, latency from push to out_valid_o is strictly one cycle.
//
// Parameters: WIDTH payload bits; DEPTH entries (1..16, any value);
// CNT_W occupancy width, >= clog2(DEPTH+1).

module pipe_stage_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage and control state
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;

  // Handshake terms
  logic empty_c;
  logic push_c;
  logic pop_c;
  logic bypass_c;
  logic bypass_pop_c;
  logic wr_en_c;
  logic rd_adv_c;

  // Pointers wrap by explicit compare, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Output side and the push/pop decode
  always_comb begin
    empty_c = (cnt_q == '0);
`ifdef PIPE_STAGE_BUF_BYPASS_EN
    bypass_c    = empty_c & in_valid_i & ~flush_i;
    out_valid_o = (~empty_c & ~flush_i) | bypass_c;
    out_data_o  = bypass_c ? in_data_i : mem_q[rd_ptr_q];
`else
    bypass_c    = 1'b0;
    out_valid_o = ~empty_c & ~flush_i;
    out_data_o  = mem_q[rd_ptr_q];
`endif
    in_ready_o   = in_ready_q;
    count_o      = cnt_q;
    push_c       = in_valid_i & in_ready_q & ~flush_i;
    pop_c        = out_valid_o & out_ready_i & ~stall_i;
    // A bypassed word that is consumed at once never touches storage.
    bypass_pop_c = bypass_c & pop_c;
    wr_en_c      = push_c & ~bypass_pop_c;
    rd_adv_c     = pop_c & ~bypass_pop_c;
  end

  // Next-state logic; flush wins over everything else
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en_c) begin
        mem_d[wr_ptr_q] = in_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_adv_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(wr_en_c) - CNT_W'(rd_adv_c);
    end
    // Ready is registered from the next count, so it never depends on out_ready_i.
    in_ready_d = (cnt_d != FULL_CNT);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Occupancy sanity
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
    cnt_q <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_c && (cnt_q == FULL_CNT)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
`timescale 1ns/1ps
// Scoreboarded bench for pipe_stage_buf: DUT a (DEPTH=2) runs the directed
// tests, and DUT b (DEPTH=3) runs the pointer-wrap sequence.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a (DEPTH=2)
  logic        flush, stall, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  count;

  // DUT b (DEPTH=3)
  logic        b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_count;

  int errors = 0;
  int checks = 0;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(5)) u_a (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .CNT_W(5)) u_b (
    .clk_i(clk), .rst_i(rst_n), .flush_i(b_flush), .stall_i(b_stall),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for DUT a
  logic [31:0] sb_q[$];
  int          n_pop = 0;

  always @(negedge clk) begin : mon_a
    logic exp_v;
    if (rst_n !== 1'b1) begin
      sb_q.delete();
    end else begin
      exp_v = (sb_q.size() != 0) && !flush;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
      exp_v = exp_v || ((sb_q.size() == 0) && in_valid && !flush);
`endif
      chk("a_out_valid", 32'(out_valid), 32'(exp_v));
      chk("a_count",     32'(count),     32'(sb_q.size()));
      chk("a_in_ready",  32'(in_ready),  32'(sb_q.size() != 2));
      if (flush) begin
        sb_q.delete();
      end else begin
`ifdef PIPE_STAGE_BUF_BYPASS_EN
        if (in_valid && in_ready) sb_q.push_back(in_data);
`endif
        if (out_valid && out_ready && !stall) begin
          if (sb_q.size() == 0) chk("a_pop_on_empty", 32'(out_valid), 32'd0);
          else                  chk("a_out_data", out_data, sb_q.pop_front());
          n_pop++;
        end
`ifndef PIPE_STAGE_BUF_BYPASS_EN
        if (in_valid && in_ready) sb_q.push_back(in_data);
`endif
      end
    end
  end

  // Scoreboard for DUT b
  logic [31:0] sb_b[$];
  int          b_npop = 0;
  int          b_sent = 0;

  always @(negedge clk) begin : mon_b
    if (rst_n !== 1'b1) begin
      sb_b.delete();
    end else begin
      chk("b_count_max", 32'(b_count <= 5'd3), 32'd1);
      chk("b_count",     32'(b_count), 32'(sb_b.size()));
`ifdef PIPE_STAGE_BUF_BYPASS_EN
      if (b_in_valid && b_in_ready) begin sb_b.push_back(b_in_data); b_sent++; end
`endif
      if (b_out_valid && b_out_ready) begin
        if (sb_b.size() == 0) chk("b_pop_on_empty", 32'(b_out_valid), 32'd0);
        else                  chk("b_out_data", b_out_data, sb_b.pop_front());
        b_npop++;
      end
`ifndef PIPE_STAGE_BUF_BYPASS_EN
      if (b_in_valid && b_in_ready) begin sb_b.push_back(b_in_data); b_sent++; end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          p0;
    logic [15:0] vpat;
    logic [15:0] rpat;

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_stall = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    rst_n = 1'b1;
    step();

    // Fill to full, refuse a third word, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    chk("fill_count", 32'(count), 32'd2);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_data = 32'hC; step();
    chk("fill_refuse_count", 32'(count), 32'd2);
    chk("fill_head", out_data, 32'hA);
    out_ready = 1'b1; step();
    chk("drain_head_b", out_data, 32'hB);
    chk("drain_count1", 32'(count), 32'd1);
    step();
    chk("drain_head_c", out_data, 32'hC);
    chk("drain_count2", 32'(count), 32'd1);
    in_valid = 1'b0; step();
    chk("drain_empty", 32'(count), 32'd0);

    // Streaming words 1..16 at full rate
    p0 = n_pop;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 32'(i);
      step();
      if (i == 1) begin
        chk("stream_first_valid", 32'(out_valid), 32'd1);
        chk("stream_first_data",  out_data,       32'd1);
      end
    end
`ifdef PIPE_STAGE_BUF_BYPASS_EN
    chk("stream_rate", 32'(n_pop - p0), 32'd16);
`else
    chk("stream_rate", 32'(n_pop - p0), 32'd15);
`endif
    in_valid = 1'b0; step();
    chk("stream_total", 32'(n_pop - p0), 32'd16);
    chk("stream_count", 32'(count), 32'd0);

    // Flush with a full buffer and an incoming word
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    chk("flush_pre_count", 32'(count), 32'd2);
    flush = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    step(); step();
    chk("flush_no_out", 32'(out_valid), 32'd0);

    // Stall holds the head while upstream fills the buffer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; step();
    stall = 1'b1; out_ready = 1'b1; in_data = 32'h66;
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_head0", out_data, 32'h55);
    step();
    chk("stall_count", 32'(count), 32'd2);
    chk("stall_ready", 32'(in_ready), 32'd0);
    chk("stall_head1", out_data, 32'h55);
    in_data = 32'h77; step();
    chk("stall_count2", 32'(count), 32'd2);
    chk("stall_head2", out_data, 32'h55);
    stall = 1'b0; in_valid = 1'b0; step();
    chk("unstall_head", out_data, 32'h66);
    step();
    chk("unstall_empty", 32'(count), 32'd0);

    // Asynchronous reset while holding two words
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD1; step();
    in_data = 32'hD2; step();
    chk("mrst_pre_count", 32'(count), 32'd2);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    chk("mrst_count",     32'(count),     32'd0);
    chk("mrst_out_data",  out_data,       32'd0);
    step();
    rst_n = 1'b1;
    step();

    // DEPTH=3: ten words through irregular valid/ready patterns
    vpat = 16'b1110_1101_0111_1111;
    rpat = 16'b1101_0110_1001_0000;
    for (int c = 0; c < 300 && b_npop < 10; c++) begin
      b_in_valid  = (b_sent < 10) && vpat[c % 16];
      b_in_data   = 32'hB0 + 32'(b_sent);
      b_out_ready = rpat[c % 16];
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    chk("b_words_out", 32'(b_npop), 32'd10);
    chk("b_end_count", 32'(b_count), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
